hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller that produces the stall and flush controls consumed by the PC, IF/ID and ID/EX pipeline registers. It detects load-use hazards, squashes wrong-path instructions on an EX-stage redirect, and sequences multi-cycle multiply/divide occupancy with a latency counter, stalling dependent ID-stage instructions until the result is ready. It sits beside the decoder in ID and observes the ID/EX register outputs.

## Interface
Parameters:
- MULT_LAT, 4, multiply occupancy in cycles (1..63)
- DIV_LAT, 32, divide occupancy in cycles (1..63)
- CNT_W, 6, width of the occupancy counter

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; asynchronous, active-low
- IDRs  in  5  rs field of the ID-stage instruction
- IDRt  in  5  rt field of the ID-stage instruction
- IDUsesRs  in  1  ID instruction reads rs
- IDUsesRt  in  1  ID instruction reads rt
- IDMdDep  in  1  ID instruction is a mult/div or reads HI/LO
- IDEXMemRead  in  1  instruction in EX is a load
- IDEXRegRd  in  5  destination register of the instruction in EX
- ExRedirect  in  1  EX resolved a taken branch/jump
- MdStart  in  1  mult/div issued in EX this cycle
- MdIsDiv  in  1  qualifies MdStart: 1 = divide, 0 = multiply
- PCStall  out  1  hold PC
- IFIDStall  out  1  hold IF/ID
- IFIDFlush  out  1  clear IF/ID
- IDEXStall  out  1  hold ID/EX (constant 0 in this revision)
- IDEXFlush  out  1  insert a bubble into ID/EX
- MdBusy  out  1  multi-cycle unit occupied
- MdDone  out  1  one-cycle pulse on the last busy cycle
- ErrOverlap  out  1  sticky: MdStart seen while busy
- StallCycles  out  32  saturating count of cycles with PCStall=1

## Operation
- State: IDLE, MD_BUSY. Counter `cnt` (CNT_W bits).
- IDLE -> MD_BUSY on MdStart: cnt <= MdIsDiv ? DIV_LAT : MULT_LAT.
- MD_BUSY: cnt decrements each cycle. When cnt==1, MdDone=1 and next state is IDLE. MdBusy=1 in MD_BUSY.
- MdStart while in MD_BUSY: ignored (counter is not reloaded), ErrOverlap <= 1. ErrOverlap is cleared only by reset.
- Load-use hazard LU = IDEXMemRead & (IDEXRegRd!=0) & ((IDUsesRs & IDRs==IDEXRegRd) | (IDUsesRt & IDRt==IDEXRegRd)).
- Multi-cycle hazard MH = MdBusy & IDMdDep.
- Priority, highest first:
  - ExRedirect: IFIDFlush=1, IDEXFlush=1, PCStall=0, IFIDStall=0. The redirect overrides LU/MH because the ID instruction is wrong-path. The counter keeps running.
  - LU or MH: PCStall=1, IFIDStall=1, IDEXFlush=1.
  - Otherwise all of these outputs are 0.
- StallCycles increments on each rising edge with PCStall=1 and saturates at 32'hFFFF_FFFF.

## Timing
- Stall/flush outputs are combinational from the inputs and the current state; there is no added latency. They are sampled by the pipeline registers at their update edge within the same cycle.
- State, cnt, ErrOverlap and StallCycles update on the rising edge of clk.
- Reset asserted (async): state=IDLE, cnt=0, MdBusy=0, MdDone=0, ErrOverlap=0, StallCycles=0. All stall/flush outputs are forced to 0 while rst=0.
- Reset mid-MD_BUSY aborts immediately; no MdDone pulse is produced.
- A load-use stall lasts exactly 1 cycle, because the load advances to MEM.
- An MH stall lasts until the cycle after MdDone: ID is released in the first IDLE cycle.
- An MdStart in the same cycle that MdDone=1 is treated as busy: ErrOverlap is set and the start is ignored.
- Register 0 never causes a load-use hazard.

## Structure
- Shared package (pipeline_pkg): the state encoding (IDLE=0, MD_BUSY=1) and the default latency constants MULT_LAT_DEF and DIV_LAT_DEF.
- One natural sub-module: md_occupancy (FSM, counter, MdDone, ErrOverlap).
- The hazard comparison, priority logic and StallCycles counter stay in hazard_ctrl.

## Test plan
- Load r5 in EX (IDEXMemRead=1, IDEXRegRd=5); ID reads rs=5 -> PCStall=IFIDStall=IDEXFlush=1 for 1 cycle; StallCycles=1.
- Load to r0; ID reads r0 -> no stall.
- MdStart with MdIsDiv=1 (DIV_LAT=32); ID has IDMdDep=1 -> MdBusy for 32 cycles, MdDone pulses on cycle 32, ID released the next cycle; StallCycles=32.
- Load-use hazard and ExRedirect in the same cycle -> IFIDFlush=IDEXFlush=1, PCStall=0.
- MdStart at cycle 2 of a multiply (MULT_LAT=4) -> ErrOverlap=1, MdDone still fires at original cycle 4.
- rst=0 in MD_BUSY with cnt=10 -> MdBusy=0 immediately, no MdDone; after release state=IDLE.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared state encoding and default latencies for the hazard controller
package pipeline_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam int MULT_LAT_DEF = 4;
    localparam int DIV_LAT_DEF  = 32;

endpackage

// File: rtl/md_occupancy.sv
// md_occupancy: tracks mult/div unit occupancy with a latency counter
module md_occupancy
    import pipeline_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done,
    output logic err_overlap
);

    md_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // Next state/count; a start while busy (including the done cycle) is ignored
    always_comb begin
        busy      = state == MD_BUSY;
        done      = busy && cnt == CNT_W'(1);
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!busy && start) begin
            state_nxt = MD_BUSY;
            cnt_nxt   = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (busy) begin
            cnt_nxt   = cnt - CNT_W'(1);
            state_nxt = done ? IDLE : MD_BUSY;
        end
    end

    // State, counter and sticky overlap error; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            err_overlap <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (busy && start) err_overlap <= 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / mult-div hazard detection and redirect squash controls
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  IDRs,
    input  logic [4:0]  IDRt,
    input  logic        IDUsesRs,
    input  logic        IDUsesRt,
    input  logic        IDMdDep,
    input  logic        IDEXMemRead,
    input  logic [4:0]  IDEXRegRd,
    input  logic        ExRedirect,
    input  logic        MdStart,
    input  logic        MdIsDiv,
    output logic        PCStall,
    output logic        IFIDStall,
    output logic        IFIDFlush,
    output logic        IDEXStall,
    output logic        IDEXFlush,
    output logic        MdBusy,
    output logic        MdDone,
    output logic        ErrOverlap,
    output logic [31:0] StallCycles
);

    logic lu, mh, hz;

    md_occupancy #(
        .MULT_LAT(MULT_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_md (
        .clk        (clk),
        .rst        (rst),
        .start      (MdStart),
        .is_div     (MdIsDiv),
        .busy       (MdBusy),
        .done       (MdDone),
        .err_overlap(ErrOverlap)
    );

    // Hazard detection and priority; a redirect wins because ID holds a wrong-path instruction
    always_comb begin
        lu = IDEXMemRead && IDEXRegRd != 5'd0 &&
             ((IDUsesRs && IDRs == IDEXRegRd) || (IDUsesRt && IDRt == IDEXRegRd));
        mh        = MdBusy && IDMdDep;
        hz        = rst && (lu || mh);
        IFIDFlush = rst && ExRedirect;
        PCStall   = hz && !ExRedirect;
        IFIDStall = hz && !ExRedirect;
        IDEXFlush = IFIDFlush || hz;
        IDEXStall = 1'b0;
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) StallCycles <= '0;
        else if (PCStall && StallCycles != 32'hFFFF_FFFF) StallCycles <= StallCycles + 32'd1;
    end

endmodule
